// File: rtl/fir_pkg.sv
// Shared constants for the 5-tap low-pass FIR: widths, output scaling and coefficients.
package fir_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned OUT_W  = 10;
    localparam int unsigned TAPS   = 5;
    localparam int unsigned SHIFT  = 2;
    // 255 * (5+4+3+2+1) = 3825 fits in 12 bits, so the sum can never wrap
    localparam int unsigned ACC_W  = 12;

    localparam int unsigned COEF [TAPS] = '{5, 4, 3, 2, 1};

endpackage

// File: rtl/fir_tap_reg.sv
// One delay-line stage: a sample-wide register cleared asynchronously by rst.
module fir_tap_reg
    import fir_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/filter_fir.sv
// Direct-form 5-tap FIR: delay line of tap registers, combinational MAC, registered
// output scaled down by SHIFT with plain truncation.
module filter_fir
    import fir_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] x,
    output logic [OUT_W-1:0]  dataout
);

    // dline[k] holds x delayed by k samples
    logic [DATA_W-1:0] dline [1:TAPS-1];
    logic [ACC_W-1:0]  acc;
    logic [OUT_W-1:0]  dataout_d;

    for (genvar i = 1; i < TAPS; i++) begin : g_dline
        if (i == 1) begin : g_first
            fir_tap_reg #(
                .WIDTH(DATA_W)
            ) u_tap (
                .clk(clk),
                .rst(rst),
                .d  (x),
                .q  (dline[i])
            );
        end else begin : g_rest
            fir_tap_reg #(
                .WIDTH(DATA_W)
            ) u_tap (
                .clk(clk),
                .rst(rst),
                .d  (dline[i-1]),
                .q  (dline[i])
            );
        end
    end

    always_comb begin
        acc = ACC_W'(COEF[0]) * ACC_W'(x);
        for (int i = 1; i < TAPS; i++) begin
            acc = acc + ACC_W'(COEF[i]) * ACC_W'(dline[i]);
        end
    end

    assign dataout_d = OUT_W'(acc >> SHIFT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dataout <= '0;
        end else begin
            dataout <= dataout_d;
        end
    end

endmodule

// File: tb/tb_filter_fir.sv
// Self-checking bench for filter_fir: directed scenarios plus random samples against
// an arithmetic model of the filter built from a sample-history array.
module tb_filter_fir;

    logic       clk;
    logic       rst;
    logic [7:0] x;
    logic [9:0] dataout;

    int checks;
    int errors;

    // hist[0] is the previous sample, hist[3] the oldest
    int hist [4];

    filter_fir dut (
        .clk    (clk),
        .rst    (rst),
        .x      (x),
        .dataout(dataout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_clear();
        for (int i = 0; i < 4; i++) hist[i] = 0;
    endfunction

    // Output produced at the edge that samples xv, then history shifts.
    function automatic int model_edge(input int xv);
        int y;
        y = (5 * xv + 4 * hist[0] + 3 * hist[1] + 2 * hist[2] + 1 * hist[3]) / 4;
        hist[3] = hist[2];
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = xv;
        return y;
    endfunction

    // Drive a sample, clock it in, return to 1 ns after the edge.
    task automatic step(input int xv, output int expv);
        x = 8'(xv);
        @(posedge clk);
        #1;
        expv = model_edge(xv);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #3;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        int e;
        for (int i = 0; i < 6; i++) step(int'($urandom_range(255)), e);
        rst = 1'b1;
        #2;
        checks++;
        if (dataout !== 10'd0) begin
            errors++;
            $display("FAIL reset_async: dataout=%0d want 0", dataout);
        end
        rst = 1'b0;
        model_clear();
        for (int i = 0; i < 5; i++) begin
            step(int'($urandom_range(255)), e);
            checks++;
            if (dataout !== 10'(e)) begin
                errors++;
                $display("FAIL reset_history[%0d]: dataout=%0d want %0d", i, dataout, e);
            end
        end
    endtask

    task automatic test_sequence();
        int xs [5] = '{5, 10, 12, 15, 16};
        int ys [5] = '{6, 17, 28, 40, 50};
        int e;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(xs[i], e);
            checks++;
            if (dataout !== 10'(ys[i])) begin
                errors++;
                $display("FAIL sequence[%0d]: dataout=%0d want %0d", i, dataout, ys[i]);
            end
        end
    endtask

    task automatic test_impulse();
        int ys [6] = '{125, 100, 75, 50, 25, 0};
        int e;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step((i == 0) ? 100 : 0, e);
            checks++;
            if (dataout !== 10'(ys[i])) begin
                errors++;
                $display("FAIL impulse[%0d]: dataout=%0d want %0d", i, dataout, ys[i]);
            end
        end
    endtask

    task automatic test_full_scale();
        // floor(255 * partial coefficient sum / 4)
        int ys [7] = '{318, 573, 765, 892, 956, 956, 956};
        int e;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step(255, e);
            checks++;
            if (dataout !== 10'(ys[i])) begin
                errors++;
                $display("FAIL full_scale[%0d]: dataout=%0d want %0d", i, dataout, ys[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        int e;
        do_reset();
        step(5, e);
        step(10, e);
        step(12, e);
        rst = 1'b1;
        #2;
        checks++;
        if (dataout !== 10'd0) begin
            errors++;
            $display("FAIL mid_reset_async: dataout=%0d want 0", dataout);
        end
        rst = 1'b0;
        model_clear();
        step(8, e);
        checks++;
        if (dataout !== 10'd10) begin
            errors++;
            $display("FAIL mid_reset_next: dataout=%0d want 10", dataout);
        end
    endtask

    task automatic test_constant();
        int ys [7] = '{5, 9, 12, 14, 15, 15, 15};
        int e;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step(4, e);
            checks++;
            if (dataout !== 10'(ys[i])) begin
                errors++;
                $display("FAIL constant[%0d]: dataout=%0d want %0d", i, dataout, ys[i]);
            end
        end
    endtask

    // Random stream with glitches on x between edges that must be ignored.
    task automatic test_random();
        int e;
        int v;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            v = int'($urandom_range(255));
            x = 8'($urandom_range(255));
            #2;
            x = 8'(v);
            @(posedge clk);
            #1;
            e = model_edge(v);
            x = 8'($urandom_range(255));
            checks++;
            if (dataout !== 10'(e)) begin
                errors++;
                $display("FAIL random[%0d]: x=%0d dataout=%0d want %0d", i, v, dataout, e);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        x = '0;
        rst = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
        checks++;
        if (dataout !== 10'd0) begin
            errors++;
            $display("FAIL power_on_reset: dataout=%0d want 0", dataout);
        end
        rst = 1'b0;

        test_reset();
        test_sequence();
        test_impulse();
        test_full_scale();
        test_mid_reset();
        test_constant();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
